// File: rtl/data_mem_responder_if.sv
// Load/store port between the core-side LSU wrapper (master) and the data memory responder (slave).
interface data_mem_responder_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
);
    logic                   Load;
    logic                   mem_en;
    logic [AddrWidth+1:0]   addr;
    logic [3:0]             masking;
    logic [DataWidth-1:0]   data_i;
    logic [DataWidth-1:0]   data_o;
    logic                   data_valid;
    logic                   busy;

    modport master (
        output Load, mem_en, addr, masking, data_i,
        input  data_o, data_valid, busy
    );

    modport slave (
        input  Load, mem_en, addr, masking, data_i,
        output data_o, data_valid, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: byte-masked stores, word loads returned after a fixed latency
// with a one-cycle data_valid pulse.
module data_mem_responder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10,
    parameter int Latency   = 2
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_responder_if.slave  bus
);
    localparam int CntWidth = $clog2(16);
    localparam logic [CntWidth-1:0] CntInit = CntWidth'(Latency - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CntWidth-1:0]    cnt;
    logic [DataWidth-1:0]   rdata;
    logic [DataWidth-1:0]   data_hold;
    logic [DataWidth-1:0]   mem [2**AddrWidth];

    logic                   busy_int;
    logic                   load_acc;
    logic                   store_acc;
    logic [AddrWidth-1:0]   word_idx;
    logic                   unused_addr_bits;

    assign busy_int         = (state == WAIT);
    assign store_acc        = bus.mem_en & ~busy_int;
    // A simultaneous load and store is treated as a store; the load is dropped.
    assign load_acc         = bus.Load & ~bus.mem_en & ~busy_int;
    assign word_idx         = bus.addr[AddrWidth+1:2];
    assign unused_addr_bits = ^bus.addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESP: begin
                if (load_acc) begin
                    next_state = (Latency == 1) ? RESP : WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt == CntWidth'(1)) begin
                    next_state = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = busy_int;
        bus.data_valid = (state == RESP);
        bus.data_o     = (state == RESP) ? rdata : data_hold;
    end

    // rdata is overwritten by a load accepted in RESP, so data_hold keeps the
    // last returned word visible until the next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            rdata     <= '0;
            data_hold <= '0;
        end else begin
            if (state == RESP) begin
                data_hold <= rdata;
            end
            if (load_acc) begin
                cnt   <= CntInit;
                rdata <= mem[word_idx];
            end else if (state == WAIT) begin
                cnt <= cnt - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_acc) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.masking[k]) begin
                    mem[word_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (Latency 2, 3, 1) share one stimulus stream;
// each scenario checks the instance whose latency it targets.
module tb_data_mem_responder;
    logic        clk;
    logic        rst;
    logic        load;
    logic        mem_en;
    logic [11:0] addr;
    logic [3:0]  masking;
    logic [31:0] data_i;

    int compared   = 0;
    int mismatched = 0;
    int busy1_seen = 0;
    int dv3_seen   = 0;
    logic [15:0] alias_addr;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus3 ();
    data_mem_responder_if bus1 ();

    assign bus2.Load = load;  assign bus2.mem_en = mem_en;  assign bus2.addr = addr;
    assign bus2.masking = masking;  assign bus2.data_i = data_i;
    assign bus3.Load = load;  assign bus3.mem_en = mem_en;  assign bus3.addr = addr;
    assign bus3.masking = masking;  assign bus3.data_i = data_i;
    assign bus1.Load = load;  assign bus1.mem_en = mem_en;  assign bus1.addr = addr;
    assign bus1.masking = masking;  assign bus1.data_i = data_i;

    data_mem_responder #(.Latency(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    data_mem_responder #(.Latency(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    data_mem_responder #(.Latency(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus1.busy === 1'b1) busy1_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request for a cycle, then land 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic ld, input logic st, input logic [11:0] a,
                                 input logic [3:0] m, input logic [31:0] d);
        load = ld; mem_en = st; addr = a; masking = m; data_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        load = 1'b0; mem_en = 1'b0; addr = '0; masking = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data_o",     bus2.data_o, 32'h0);
        checkOutput("rst_data_valid", {31'b0, bus2.data_valid}, 32'h0);
        checkOutput("rst_busy",       {31'b0, bus2.busy}, 32'h0);
        rst = 1'b1;
        idle(1);

        $display("[TB] word store then load, Latency=2");
        applyStimulus(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        checkOutput("st_no_valid", {31'b0, bus2.data_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        checkOutput("ld_busy_n1",  {31'b0, bus2.busy}, 32'h1);
        checkOutput("ld_valid_n1", {31'b0, bus2.data_valid}, 32'h0);
        checkOutput("l1_valid_n1", {31'b0, bus1.data_valid}, 32'h1);
        checkOutput("l1_data_n1",  bus1.data_o, 32'hDEADBEEF);
        idle(1);
        checkOutput("ld_valid_n2", {31'b0, bus2.data_valid}, 32'h1);
        checkOutput("ld_data_n2",  bus2.data_o, 32'hDEADBEEF);
        checkOutput("ld_busy_n2",  {31'b0, bus2.busy}, 32'h0);
        idle(1);
        checkOutput("ld_valid_n3", {31'b0, bus2.data_valid}, 32'h0);
        checkOutput("ld_hold_n3",  bus2.data_o, 32'hDEADBEEF);
        idle(3);

        $display("[TB] byte-lane merge");
        applyStimulus(1'b0, 1'b1, 12'h020, 4'hF, 32'h11223344);
        applyStimulus(1'b0, 1'b1, 12'h020, 4'b0100, 32'h00AA0000);
        applyStimulus(1'b0, 1'b1, 12'h020, 4'b0000, 32'hFFFFFFFF);
        applyStimulus(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        idle(1);
        checkOutput("merge_valid", {31'b0, bus2.data_valid}, 32'h1);
        checkOutput("merge_data",  bus2.data_o, 32'h11AA3344);
        idle(3);

        $display("[TB] busy rejection, Latency=3");
        applyStimulus(1'b0, 1'b1, 12'h004, 4'hF, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 12'h004, 4'h0, 32'h0);
        checkOutput("busy_n1", {31'b0, bus3.busy}, 32'h1);
        applyStimulus(1'b0, 1'b1, 12'h004, 4'hF, 32'hFFFFFFFF);
        checkOutput("busy_n2",       {31'b0, bus3.busy}, 32'h1);
        checkOutput("busy_valid_n2", {31'b0, bus3.data_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 12'h008, 4'h0, 32'h0);
        checkOutput("busy_valid_n3", {31'b0, bus3.data_valid}, 32'h1);
        checkOutput("busy_data_n3",  bus3.data_o, 32'hA5A5A5A5);
        checkOutput("busy_clear_n3", {31'b0, bus3.busy}, 32'h0);
        idle(1);
        checkOutput("busy_single_pulse", {31'b0, bus3.data_valid}, 32'h0);
        idle(4);
        applyStimulus(1'b1, 1'b0, 12'h004, 4'h0, 32'h0);
        idle(2);
        checkOutput("busy_reread_valid", {31'b0, bus3.data_valid}, 32'h1);
        checkOutput("busy_reread_data",  bus3.data_o, 32'hA5A5A5A5);
        idle(4);

        $display("[TB] back-to-back loads, Latency=2");
        applyStimulus(1'b0, 1'b1, 12'h030, 4'hF, 32'h01010101);
        applyStimulus(1'b0, 1'b1, 12'h034, 4'hF, 32'h02020202);
        applyStimulus(1'b0, 1'b1, 12'h038, 4'hF, 32'h03030303);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 12'h030 + 12'(4*i), 4'h0, 32'h0);
            checkOutput($sformatf("b2b_wait_valid_%0d", i), {31'b0, bus2.data_valid}, 32'h0);
            applyStimulus(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
            checkOutput($sformatf("b2b_valid_%0d", i), {31'b0, bus2.data_valid}, 32'h1);
            checkOutput($sformatf("b2b_data_%0d", i), bus2.data_o, 32'h01010101 * (i + 1));
        end
        idle(4);

        $display("[TB] load every cycle, Latency=1");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 12'h030 + 12'(4*i), 4'h0, 32'h0);
            checkOutput($sformatf("l1_valid_%0d", i), {31'b0, bus1.data_valid}, 32'h1);
            checkOutput($sformatf("l1_data_%0d", i),  bus1.data_o, 32'h01010101 * (i + 1));
        end
        idle(1);
        checkOutput("l1_valid_end", {31'b0, bus1.data_valid}, 32'h0);
        idle(4);

        $display("[TB] simultaneous load+store and address alias");
        applyStimulus(1'b0, 1'b1, 12'h00C, 4'hF, 32'h00000000);
        alias_addr = 16'h100C;
        applyStimulus(1'b1, 1'b1, alias_addr[11:0], 4'hF, 32'h12345678);
        checkOutput("both_busy", {31'b0, bus2.busy}, 32'h0);
        idle(1);
        checkOutput("both_no_valid_n2", {31'b0, bus2.data_valid}, 32'h0);
        idle(1);
        checkOutput("both_no_valid_n3", {31'b0, bus2.data_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 12'h00C, 4'h0, 32'h0);
        idle(1);
        checkOutput("alias_valid", {31'b0, bus2.data_valid}, 32'h1);
        checkOutput("alias_data",  bus2.data_o, 32'h12345678);
        idle(4);

        $display("[TB] reset mid-load, Latency=3");
        applyStimulus(1'b0, 1'b1, 12'h040, 4'hF, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 12'h040, 4'h0, 32'h0);
        load = 1'b0; mem_en = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy",   {31'b0, bus3.busy}, 32'h0);
        checkOutput("midrst_data_o", bus3.data_o, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b1;
            applyStimulus(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
            if (bus3.data_valid === 1'b1) dv3_seen++;
        end
        checkOutput("midrst_no_valid", 32'(dv3_seen), 32'h0);
        checkOutput("midrst_data_after", bus3.data_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 12'h040, 4'h0, 32'h0);
        idle(2);
        checkOutput("midrst_reread_valid", {31'b0, bus3.data_valid}, 32'h1);
        checkOutput("midrst_reread_data",  bus3.data_o, 32'hCAFEF00D);
        idle(2);

        checkOutput("l1_busy_never", 32'(busy1_seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
